// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver:
// parity modes, receiver states, mid-bit count and parity check.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } rx_state_e;

    function automatic int mid_bit_count(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

    // Data is zero-extended to 9 bits, so unused upper bits do not disturb the XOR.
    function automatic logic parity_error(input logic [8:0] data,
                                          input logic sample,
                                          input parity_mode_e mode);
        logic sum_s;
        sum_s = (^data) ^ sample;
        case (mode)
            PAR_ODD:  return ~sum_s;
            PAR_EVEN: return sum_s;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input,
// with a configurable reset value (1 for an idle-high serial line).
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data, optional parity, 1 or 2 stop bits,
// start-glitch rejection, parity/framing flags and break detection.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int           CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int           BIT_W    = $clog2(DATA_BITS + 1);
    localparam int           MID      = mid_bit_count(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam parity_mode_e PAR_MODE = parity_mode_e'(PARITY[1:0]);

    logic                 rxs_s;
    rx_state_e            state_r, state_n;
    logic [CNT_W-1:0]     clk_cnt_r, clk_cnt_n;
    logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic                 par_err_r, par_err_n;
    logic                 frm_err_r, frm_err_n;
    logic                 brk_r, brk_n;
    logic                 tick_s;
    logic                 done_s;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs_s)
    );

    // The start bit is sampled at mid-bit; every later bit one full period after the previous sample.
    assign tick_s = (state_r == S_START) ? (clk_cnt_r == CNT_MID) : (clk_cnt_r == CNT_LAST);

    // next-state, bit timing and frame accumulation
    always_comb begin
        state_n   = state_r;
        clk_cnt_n = {CNT_W{1'b0}};
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        par_err_n = par_err_r;
        frm_err_n = frm_err_r;
        brk_n     = brk_r;
        done_s    = 1'b0;

        if ((state_r == S_IDLE) || (state_r == S_WAIT_IDLE) || tick_s) begin
            clk_cnt_n = {CNT_W{1'b0}};
        end else begin
            clk_cnt_n = clk_cnt_r + CNT_W'(1);
        end

        case (state_r)
            S_IDLE: begin
                if (!rxs_s) begin
                    state_n   = S_START;
                    bit_cnt_n = {BIT_W{1'b0}};
                    par_err_n = 1'b0;
                    frm_err_n = 1'b0;
                    brk_n     = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    state_n = rxs_s ? S_IDLE : S_DATA;
                end else begin
                    state_n = S_START;
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    shift_n = {rxs_s, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_cnt_n = {BIT_W{1'b0}};
                        state_n   = (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    state_n = S_DATA;
                end
            end
            S_PARITY: begin
                if (tick_s) begin
                    par_err_n = parity_error(9'(shift_r), rxs_s, PAR_MODE);
                    state_n   = S_STOP;
                end else begin
                    state_n = S_PARITY;
                end
            end
            S_STOP: begin
                if (tick_s) begin
                    frm_err_n = frm_err_r | ~rxs_s;
                    if (bit_cnt_r == {BIT_W{1'b0}}) begin
                        brk_n = (shift_r == {DATA_BITS{1'b0}}) & ~rxs_s;
                    end else begin
                        brk_n = brk_r;
                    end
                    if (bit_cnt_r == STOP_LAST) begin
                        done_s    = 1'b1;
                        bit_cnt_n = {BIT_W{1'b0}};
                        // a line still low after the frame must return high before a new start
                        state_n   = rxs_s ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    state_n = S_STOP;
                end
            end
            S_WAIT_IDLE: begin
                if (rxs_s) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_WAIT_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // state, counters and frame accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            clk_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
            brk_r     <= 1'b0;
        end else begin
            state_r   <= state_n;
            clk_cnt_r <= clk_cnt_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            par_err_r <= par_err_n;
            frm_err_r <= frm_err_n;
            brk_r     <= brk_n;
        end
    end

    // registered outputs; data and flags load only on frame completion
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= {DATA_BITS{1'b0}};
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= done_s;
            busy       <= (state_n != S_IDLE);
            if (done_s) begin
                data_out   <= shift_r;
                parity_err <= par_err_n;
                frame_err  <= frm_err_n;
                break_det  <= brk_n;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2)
// share one serial driver; expectations are queued per instance at send time.
module tb_uart_rx_cfg;

    localparam int CPB = 104;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line = 1'b1;
    int   sel = 0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   pulses_a = 0;
    int   pulses_b = 0;
    int   pulses_c = 0;
    int   t_c[$];
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    logic       rx_a, rx_b, rx_c;
    logic [7:0] dout_a, dout_b;
    logic [6:0] dout_c;
    logic       dv_a, pe_a, fe_a, bd_a, busy_a;
    logic       dv_b, pe_b, fe_b, bd_b, busy_b;
    logic       dv_c, pe_c, fe_c, bd_c, busy_c;

    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_b = (sel == 1) ? line : 1'b1;
    assign rx_c = (sel == 2) ? line : 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .rx(rx_a), .data_out(dout_a), .data_valid(dv_a),
        .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a), .busy(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .rx(rx_b), .data_out(dout_b), .data_valid(dv_b),
        .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b), .busy(busy_b)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) u_c (
        .clk(clk), .rst(rst), .rx(rx_c), .data_out(dout_c), .data_valid(dv_c),
        .parity_err(pe_c), .frame_err(fe_c), .break_det(bd_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int qsize(input int dut);
        case (dut)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    // pmode: 0 none, 1 odd, 2 even; pbit < 0 means no parity bit on the wire
    task automatic send(input int dut, input logic [8:0] data, input int nbits, input int pmode,
                        input int pbit, input logic s1, input logic s2, input int nstop);
        logic [8:0] m;
        logic       par;
        exp_t       e;
        m      = data & ((9'd1 << nbits) - 9'd1);
        par    = ^m;
        e.data = m;
        e.pe   = (pmode == 0) ? 1'b0 : (pmode == 1) ? ((par ^ pbit[0]) != 1'b1) : ((par ^ pbit[0]) != 1'b0);
        e.fe   = !s1 || ((nstop == 2) && !s2);
        e.bd   = (m == 9'd0) && !s1;
        case (dut)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
        sel  = dut;
        line = 1'b0;
        cycles(CPB);
        for (int i = 0; i < nbits; i++) begin
            line = m[i];
            cycles(CPB);
        end
        if (pbit >= 0) begin
            line = pbit[0];
            cycles(CPB);
        end
        line = s1;
        cycles(CPB);
        if (nstop == 2) begin
            line = s2;
            cycles(CPB);
        end
    endtask

    task automatic drain(input int dut, input int budget);
        for (int i = 0; (i < budget) && (qsize(dut) != 0); i++) cycles(1);
        check($sformatf("drain_%0d", dut), 16'(qsize(dut)), 16'd0);
    endtask

    always @(negedge clk) begin
        if (dv_a) begin
            pulses_a <= pulses_a + 1;
            if (q_a.size() != 0) begin
                check("a_data", 16'(dout_a), 16'(q_a[0].data));
                check("a_flags", 16'({pe_a, fe_a, bd_a}), 16'({q_a[0].pe, q_a[0].fe, q_a[0].bd}));
                q_a.delete(0);
            end
        end
        if (dv_b) begin
            pulses_b <= pulses_b + 1;
            if (q_b.size() != 0) begin
                check("b_data", 16'(dout_b), 16'(q_b[0].data));
                check("b_flags", 16'({pe_b, fe_b, bd_b}), 16'({q_b[0].pe, q_b[0].fe, q_b[0].bd}));
                q_b.delete(0);
            end
        end
        if (dv_c) begin
            pulses_c <= pulses_c + 1;
            t_c.push_back(cyc);
            if (q_c.size() != 0) begin
                check("c_data", 16'(dout_c), 16'(q_c[0].data));
                check("c_flags", 16'({pe_c, fe_c, bd_c}), 16'({q_c[0].pe, q_c[0].fe, q_c[0].bd}));
                q_c.delete(0);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        line = 1'b1;
        cycles(5);
        rst = 1'b0;
        cycles(2);
        check("reset_a", 16'({dout_a, dv_a, pe_a, fe_a, bd_a, busy_a}), 16'd0);

        // 8N1 0xA5
        send(0, 9'h0A5, 8, 0, -1, 1'b1, 1'b1, 1);
        line = 1'b1;
        drain(0, 200);
        check("a_busy_after", 16'(busy_a), 16'd0);
        check("a_pulses_1", 16'(pulses_a), 16'd1);

        // even parity: 0x03 with wrong parity bit 1
        send(1, 9'h003, 8, 2, 1, 1'b1, 1'b1, 1);
        line = 1'b1;
        drain(1, 200);

        // start glitch: 30 low cycles must not start a frame
        sel  = 1;
        line = 1'b0;
        cycles(10);
        check("b_glitch_busy", 16'(busy_b), 16'd1);
        cycles(20);
        line = 1'b1;
        cycles(100);
        check("b_glitch_idle", 16'(busy_b), 16'd0);
        check("b_glitch_pulses", 16'(pulses_b), 16'd1);
        check("b_glitch_hold", 16'({dout_b, pe_b}), 16'({8'h03, 1'b1}));

        // 0x03 with correct parity bit 0
        send(1, 9'h003, 8, 2, 0, 1'b1, 1'b1, 1);
        line = 1'b1;
        drain(1, 200);
        check("b_pulses_2", 16'(pulses_b), 16'd2);

        // break: all-zero data, low stop bit, line held low
        send(0, 9'h000, 8, 0, -1, 1'b0, 1'b1, 1);
        drain(0, 200);
        cycles(1800);
        check("a_break_busy", 16'(busy_a), 16'd1);
        check("a_break_pulses", 16'(pulses_a), 16'd2);
        line = 1'b1;
        cycles(20);
        check("a_break_release", 16'(busy_a), 16'd0);
        send(0, 9'h05A, 8, 0, -1, 1'b1, 1'b1, 1);
        line = 1'b1;
        drain(0, 200);
        check("a_pulses_3", 16'(pulses_a), 16'd3);

        // 7N2 back-to-back
        send(2, 9'h055, 7, 0, -1, 1'b1, 1'b1, 2);
        send(2, 9'h02A, 7, 0, -1, 1'b1, 1'b1, 2);
        line = 1'b1;
        drain(2, 200);
        check("c_pulses", 16'(pulses_c), 16'd2);
        if (t_c.size() == 2) begin
            check("c_spacing", 16'(t_c[1] - t_c[0]), 16'(10 * CPB));
        end else begin
            check("c_stamps", 16'(t_c.size()), 16'd2);
        end

        // reset during data bit 4 of 0xFF
        sel  = 0;
        line = 1'b0;
        cycles(CPB);
        line = 1'b1;
        cycles(4 * CPB + 50);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("a_rst_outputs", 16'({dout_a, dv_a, pe_a, fe_a, bd_a, busy_a}), 16'd0);
        cycles(6 * CPB);
        check("a_rst_pulses", 16'(pulses_a), 16'd3);
        check("a_rst_quiet", 16'({dout_a, busy_a}), 16'd0);
        send(0, 9'h081, 8, 0, -1, 1'b1, 1'b1, 1);
        line = 1'b1;
        drain(0, 200);
        check("a_pulses_4", 16'(pulses_a), 16'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
